// File: rtl/i2c_xfer_sequencer.sv
// Request sequencer in front of the reduced I2C master: queues TX bytes, raises WR/RD,
// counts bytes off the master's bit strobes and captures read data into an RX FIFO.

module I2cXferFifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign doPush  = push & ~full;
    assign doPop   = pop & ~empty;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Head reads as zero when empty so the visible data is clean after reset.
    assign popData = empty ? '0 : mem[rdPtr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr_q] <= pushData;
    end
endmodule

module i2c_xfer_sequencer #(
    parameter int TX_DEPTH      = 8,
    parameter int RX_DEPTH      = 8,
    parameter int DRAIN_TIMEOUT = 200000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [7:0] byte_count,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_underflow,
    output logic       err_overflow,
    output logic       err_timeout,
    output logic       WR,
    output logic       RD,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    input  logic [3:0] main_state,
    input  logic [4:0] i2c_state,
    input  logic       scl_fallingedge,
    input  logic       ack_status
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_DRAIN, S_DONE} state_t;

    localparam int            CW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    bytesDone_q, bytesDone_d;
    logic          wr_q, wr_d, rd_q, rd_d;
    logic          errNack_q, errNack_d, errUnder_q, errUnder_d;
    logic          errOver_q, errOver_d, errTime_q, errTime_d;
    logic [CW-1:0] drainCnt_q, drainCnt_d;
    logic          txPop, txFull, txEmpty, rxPush, rxFull, rxEmpty;
    logic          evW7, evW8, evW0, evR8, evR0;

    assign evW7 = scl_fallingedge && main_state == 4'd4 && i2c_state == 5'd7;
    assign evW8 = scl_fallingedge && main_state == 4'd4 && i2c_state == 5'd8;
    assign evW0 = scl_fallingedge && main_state == 4'd4 && i2c_state == 5'd0;
    assign evR8 = scl_fallingedge && main_state == 4'd3 && i2c_state == 5'd8;
    assign evR0 = scl_fallingedge && main_state == 4'd3 && i2c_state == 5'd0;

    I2cXferFifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) txFifo (
        .clock(clock), .reset(reset), .push(tx_valid), .pushData(tx_data),
        .pop(txPop), .popData(wdata), .full(txFull), .empty(txEmpty)
    );

    I2cXferFifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) rxFifo (
        .clock(clock), .reset(reset), .push(rxPush), .pushData(rdata),
        .pop(rx_ready), .popData(rx_data), .full(rxFull), .empty(rxEmpty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            count_q     <= '0;
            bytesDone_q <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            errNack_q   <= 1'b0;
            errUnder_q  <= 1'b0;
            errOver_q   <= 1'b0;
            errTime_q   <= 1'b0;
            drainCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            count_q     <= count_d;
            bytesDone_q <= bytesDone_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            errNack_q   <= errNack_d;
            errUnder_q  <= errUnder_d;
            errOver_q   <= errOver_d;
            errTime_q   <= errTime_d;
            drainCnt_q  <= drainCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        count_d     = count_q;
        bytesDone_d = bytesDone_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        errNack_d   = errNack_q;
        errUnder_d  = errUnder_q;
        errOver_d   = errOver_q;
        errTime_d   = errTime_q;
        drainCnt_d  = '0;
        txPop       = 1'b0;
        rxPush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d       = dir;
                    count_d     = byte_count;
                    bytesDone_d = '0;
                    errNack_d   = 1'b0;
                    errUnder_d  = 1'b0;
                    errOver_d   = 1'b0;
                    errTime_d   = 1'b0;
                    if (byte_count == 8'd0) begin
                        state_d = S_DONE;
                    end else if (!dir && txEmpty) begin
                        errUnder_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        wr_d    = ~dir;
                        rd_d    = dir;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (main_state != 4'd0) state_d = S_XFER;
            end
            S_XFER: begin
                if (!dir_q) begin
                    if (evW7) begin
                        txPop       = 1'b1;
                        bytesDone_d = bytesDone_q + 8'd1;
                    end
                    if (evW8 && ack_status) begin
                        errNack_d = 1'b1;
                        wr_d      = 1'b0;
                        state_d   = S_DRAIN;
                    end else if (evW0 && bytesDone_q == count_q) begin
                        wr_d    = 1'b0;
                        state_d = S_DRAIN;
                    end else if (evW0 && txEmpty) begin
                        errUnder_d = 1'b1;
                        wr_d       = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end else begin
                    // A full RX drops the byte but the byte still counts toward byte_count.
                    if (evR8) begin
                        rxPush      = ~rxFull;
                        errOver_d   = errOver_q | rxFull;
                        bytesDone_d = bytesDone_q + 8'd1;
                    end
                    if (evR0 && bytesDone_q == count_q) begin
                        rd_d    = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (main_state == 4'd0) begin
                    state_d = S_DONE;
                end else if (drainCnt_q == DRAIN_LAST) begin
                    errTime_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    drainCnt_d = drainCnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign tx_ready      = ~txFull;
    assign rx_valid      = ~rxEmpty;
    assign WR            = wr_q;
    assign RD            = rd_q;
    assign err_nack      = errNack_q;
    assign err_underflow = errUnder_q;
    assign err_overflow  = errOver_q;
    assign err_timeout   = errTime_q;
endmodule
